tdm_channel_sequencer: RTL

Time-division multiplexing scheduler for the four-channel EEG analog front-end input multiplexer. It drives the one-hot channel-select switches CH1..CH4 with break-before-make dead time and a programmable settling interval. It then requests one ADC conversion per enabled channel through a req/ack handshake. The block sits between the digital configuration registers and the mux switch drivers and ADC start logic, and replaces the free-running channel counter.

---
 rtl/tdm_channel_sequencer_if.sv | 23 ++
 rtl/tdm_channel_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/tdm_channel_sequencer_if.sv
// rtl/tdm_channel_sequencer_if.sv - ADC request/acknowledge and frame status bundle
interface tdm_channel_sequencer_if;
    logic sample_req;
    logic sample_ack;
    logic frame_done;
    logic sample_timeout;

    // Sequencer side: issues requests and status pulses, receives the ADC acknowledge
    modport master (
        output sample_req,
        output frame_done,
        output sample_timeout,
        input  sample_ack
    );

    // ADC side: sees requests and status, returns the acknowledge
    modport slave (
        input  sample_req,
        input  frame_done,
        input  sample_timeout,
        output sample_ack
    );
endinterface

// File: rtl/tdm_channel_sequencer.sv
// rtl/tdm_channel_sequencer.sv - four-channel TDM mux sequencer with dead time, settling and ADC handshake
module tdm_channel_sequencer #(
    parameter int DEAD_W   = 4,
    parameter int SETTLE_W = 8,
    parameter int TO_W     = 10
) (
    input  logic                clk,
    input  logic                RST,
    input  logic                enable,
    input  logic [3:0]          ch_en,
    input  logic [DEAD_W-1:0]   dead_cycles,
    input  logic [SETTLE_W-1:0] settle_cycles,
    tdm_channel_sequencer_if.master adc,
    output logic                CH1,
    output logic                CH2,
    output logic                CH3,
    output logic                CH4,
    output logic [1:0]          ch_id,
    output logic                busy
);
    localparam int CNT_W = (DEAD_W > SETTLE_W) ? DEAD_W : SETTLE_W;
    // Last SAMPLE cycle index before giving up: 2^TO_W-1 cycles in total
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, DEAD, SETTLE, SAMPLE} state_t;

    state_t              state, state_n;
    logic [1:0]          ptr, ptr_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [TO_W-1:0]     to_cnt, to_n;
    logic [3:0]          mask, mask_n;
    logic [DEAD_W-1:0]   dead_l, dead_n;
    logic [SETTLE_W-1:0] settle_l, settle_n;
    logic [1:0]          ch_id_n;
    logic                done_n, tmo_n, start_frame;
    logic [CNT_W-1:0]    dead_last, settle_last;
    logic [2:0]          nxt;

    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Returns {found, index} of the next set bit strictly above p
    function automatic logic [2:0] next_above(input logic [3:0] m, input logic [1:0] p);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i > int'(p))) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    // Zero-length intervals are stretched to one cycle
    assign dead_last   = (dead_l == '0)   ? '0 : CNT_W'(dead_l) - CNT_W'(1);
    assign settle_last = (settle_l == '0) ? '0 : CNT_W'(settle_l) - CNT_W'(1);
    assign nxt         = next_above(mask, ptr);

    // Next-state, counter and pulse computation
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        cnt_n       = cnt;
        to_n        = to_cnt;
        mask_n      = mask;
        dead_n      = dead_l;
        settle_n    = settle_l;
        ch_id_n     = ch_id;
        done_n      = 1'b0;
        tmo_n       = 1'b0;
        start_frame = 1'b0;
        case (state)
            IDLE: begin
                start_frame = enable && (ch_en != 4'b0000);
            end
            DEAD: begin
                if (cnt == dead_last) begin
                    state_n = SETTLE;
                    cnt_n   = '0;
                    ch_id_n = ptr;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt == settle_last) begin
                    state_n = SAMPLE;
                    cnt_n   = '0;
                    to_n    = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            SAMPLE: begin
                if (adc.sample_ack || (to_cnt == TO_LAST)) begin
                    tmo_n = !adc.sample_ack;
                    cnt_n = '0;
                    if (nxt[2]) begin
                        ptr_n   = nxt[1:0];
                        state_n = DEAD;
                    end else begin
                        done_n      = 1'b1;
                        state_n     = IDLE;
                        start_frame = enable && (ch_en != 4'b0000);
                    end
                end else begin
                    to_n = to_cnt + TO_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        // Configuration is only captured at a frame boundary
        if (start_frame) begin
            state_n  = DEAD;
            mask_n   = ch_en;
            dead_n   = dead_cycles;
            settle_n = settle_cycles;
            ptr_n    = lowest_set(ch_en);
            cnt_n    = '0;
        end
    end

    // State, counters and registered outputs derived from the upcoming state
    always_ff @(posedge clk) begin
        if (RST) begin
            state              <= IDLE;
            ptr                <= 2'd0;
            cnt                <= '0;
            to_cnt             <= '0;
            mask               <= 4'b0000;
            dead_l             <= '0;
            settle_l           <= '0;
            ch_id              <= 2'd0;
            CH1                <= 1'b0;
            CH2                <= 1'b0;
            CH3                <= 1'b0;
            CH4                <= 1'b0;
            busy               <= 1'b0;
            adc.sample_req     <= 1'b0;
            adc.frame_done     <= 1'b0;
            adc.sample_timeout <= 1'b0;
        end else begin
            state              <= state_n;
            ptr                <= ptr_n;
            cnt                <= cnt_n;
            to_cnt             <= to_n;
            mask               <= mask_n;
            dead_l             <= dead_n;
            settle_l           <= settle_n;
            ch_id              <= ch_id_n;
            CH1                <= ((state_n == SETTLE) || (state_n == SAMPLE)) && (ptr_n == 2'd0);
            CH2                <= ((state_n == SETTLE) || (state_n == SAMPLE)) && (ptr_n == 2'd1);
            CH3                <= ((state_n == SETTLE) || (state_n == SAMPLE)) && (ptr_n == 2'd2);
            CH4                <= ((state_n == SETTLE) || (state_n == SAMPLE)) && (ptr_n == 2'd3);
            busy               <= (state_n != IDLE);
            adc.sample_req     <= (state_n == SAMPLE);
            adc.frame_done     <= done_n;
            adc.sample_timeout <= tmo_n;
        end
    end
endmodule
